// File: rtl/instr_packer.sv
// Packs 16/32-bit RISC-V instructions into word-aligned 32-bit blocks with halfword enables.
// Optional build macro INSTR_PACKER_DRAIN_EN adds drain_i/idle_o to push out a pending half.
module instr_packer #(
   parameter int unsigned VLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [31:0]     instr_i,
   input  logic [VLEN-1:0] addr_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [31:0]     data_o,
   output logic [VLEN-1:0] addr_o,
   output logic [1:0]      be_o
`ifdef INSTR_PACKER_DRAIN_EN
   ,
   input  logic            drain_i,
   output logic            idle_o
`endif
);

   logic            pend_q;
   logic [15:0]     low_q;
   logic [VLEN-1:0] wadr_q;

   logic            is_comp;
   logic            out_free;
   logic            addr_match;
   logic            drain;
   logic            accept;
   logic [VLEN-1:0] in_addr;
   logic [VLEN-1:0] in_word;

   logic            emit;
   logic [31:0]     emit_data;
   logic [VLEN-1:0] emit_addr;
   logic [1:0]      emit_be;
   logic            pend_d;
   logic [15:0]     low_d;
   logic [VLEN-1:0] wadr_d;

   assign in_addr    = addr_i & ~VLEN'(1);
   assign in_word    = {in_addr[VLEN-1:2], 2'b00};
   assign is_comp    = instr_i[1:0] != 2'b11;
   assign out_free   = !valid_o || ready_i;
   assign addr_match = in_addr == (wadr_q + VLEN'(2));

   // A pending low half that cannot be paired must leave on its own before new input.
`ifdef INSTR_PACKER_DRAIN_EN
   assign drain  = pend_q && ((valid_i && !addr_match) || (!valid_i && drain_i));
   assign idle_o = !pend_q && !valid_o;
`else
   assign drain  = pend_q && valid_i && !addr_match;
`endif

   assign ready_o = !flush_i && out_free && !drain;
   assign accept  = valid_i && ready_o;

   always_comb begin
      emit      = 1'b0;
      emit_data = 32'h0;
      emit_addr = in_word;
      emit_be   = 2'b00;
      pend_d    = pend_q;
      low_d     = low_q;
      wadr_d    = wadr_q;
      if (drain && out_free && !flush_i) begin
         emit      = 1'b1;
         emit_data = {16'h0, low_q};
         emit_addr = wadr_q;
         emit_be   = 2'b01;
         pend_d    = 1'b0;
      end else if (accept) begin
         if (pend_q) begin
            emit      = 1'b1;
            emit_data = {instr_i[15:0], low_q};
            emit_addr = wadr_q;
            emit_be   = 2'b11;
            pend_d    = !is_comp;
            low_d     = instr_i[31:16];
            wadr_d    = wadr_q + VLEN'(4);
         end else if (!in_addr[1]) begin
            if (is_comp) begin
               pend_d = 1'b1;
               low_d  = instr_i[15:0];
               wadr_d = in_word;
            end else begin
               emit      = 1'b1;
               emit_data = instr_i;
               emit_addr = in_word;
               emit_be   = 2'b11;
            end
         end else begin
            // Upper-half start: the low half of this word is not ours, so it stays disabled.
            emit      = 1'b1;
            emit_data = {instr_i[15:0], 16'h0};
            emit_addr = in_word;
            emit_be   = 2'b10;
            pend_d    = !is_comp;
            low_d     = instr_i[31:16];
            wadr_d    = in_word + VLEN'(4);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= 32'h0;
         addr_o  <= '0;
         be_o    <= 2'b00;
         pend_q  <= 1'b0;
         low_q   <= 16'h0;
         wadr_q  <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         if (emit) begin
            valid_o <= 1'b1;
            data_o  <= emit_data;
            addr_o  <= emit_addr;
            be_o    <= emit_be;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
         pend_q <= pend_d;
         low_q  <= low_d;
         wadr_q <= wadr_d;
      end
   end

endmodule
